// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and defaults for the FIFO write arbiter and the FIFO it feeds.
package fifo_write_arbiter_pkg;

  typedef enum logic {StIdle, StBurst} state_e;

  localparam int unsigned DefBitwidth = 5;
  localparam int unsigned DefTimeout  = 15;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter.
interface fifo_write_arbiter_if import fifo_write_arbiter_pkg::*; #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned BITWIDTH = DefBitwidth
);
  localparam int unsigned IdW = idx_width(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ*BITWIDTH-1:0] req_data;
  logic [NREQ-1:0]          req_last;
  logic [NREQ-1:0]          req_ready;
  logic                     fifo_full;
  logic                     fifo_rEn;
  logic                     fifo_wEn;
  logic [BITWIDTH-1:0]      fifo_dIn;
  logic [IdW-1:0]           grant_id;
  logic                     locked;
  logic                     timeout_err;

  modport master (
    input  req_valid, req_data, req_last, fifo_full, fifo_rEn,
    output req_ready, fifo_wEn, fifo_dIn, grant_id, locked, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_full, fifo_rEn,
    input  req_ready, fifo_wEn, fifo_dIn, grant_id, locked, timeout_err
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating-priority scan: first set request at or above ptr_i, wrapping modulo N.
module fifo_write_arbiter_rr_pick import fifo_write_arbiter_pkg::*; #(
  parameter int unsigned N = 4,
  localparam int unsigned IdW = idx_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [IdW-1:0] idx_o,
  output logic           found_o
);

  int unsigned    pos;
  logic [IdW-1:0] pos_idx;

  // Scan from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = 32'(ptr_i) + 32'(k);
      if (pos >= N) pos = pos - N;
      pos_idx = pos[IdW-1:0];
      if (req_i[pos_idx]) begin
        idx_o   = pos_idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// N-to-1 write arbiter onto a shared FIFO: round-robin between bursts, locked within a
// burst until the last beat or an idle timeout.
module fifo_write_arbiter import fifo_write_arbiter_pkg::*; #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned BITWIDTH = DefBitwidth,
  parameter int unsigned TIMEOUT  = DefTimeout
) (
  input logic                  clk,
  input logic                  rst,
  fifo_write_arbiter_if.master bus_io
);

  localparam int unsigned IdW  = idx_width(NREQ);
  localparam int unsigned CntW = idx_width(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  owner_q, owner_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  logic            pick_found;
  logic [IdW-1:0]  pick_idx;
  logic            space, has_winner, xfer, win_last;
  logic [IdW-1:0]  winner;

  function automatic logic [IdW-1:0] next_idx(logic [IdW-1:0] i);
    return (32'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  fifo_write_arbiter_rr_pick #(
    .N(NREQ)
  ) u_rr_pick (
    .req_i   (bus_io.req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // A full FIFO still takes a write when it is being read in the same cycle.
  always_comb begin
    space = !bus_io.fifo_full | bus_io.fifo_rEn;
    if (state_q == StBurst) begin
      winner     = owner_q;
      has_winner = bus_io.req_valid[owner_q];
    end else begin
      winner     = pick_idx;
      has_winner = pick_found;
    end
    win_last = bus_io.req_last[winner];
    xfer     = !rst && has_winner && space;

    bus_io.req_ready = '0;
    if (!rst && has_winner) bus_io.req_ready[winner] = space;
    bus_io.fifo_wEn = xfer;
    bus_io.fifo_dIn = '0;
    if (!rst && has_winner) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (winner == IdW'(i)) bus_io.fifo_dIn = bus_io.req_data[i*BITWIDTH +: BITWIDTH];
      end
    end

    if (rst) begin
      bus_io.grant_id = '0;
    end else if (state_q == StBurst) begin
      bus_io.grant_id = owner_q;
    end else begin
      bus_io.grant_id = pick_found ? pick_idx : grant_q;
    end
    bus_io.locked      = (state_q == StBurst);
    bus_io.timeout_err = timeout_err_q;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = 1'b0;
    grant_d       = bus_io.grant_id;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (win_last) begin
            rr_ptr_d = next_idx(winner);
          end else begin
            state_d    = StBurst;
            owner_d    = winner;
            idle_cnt_d = '0;
          end
        end
      end
      StBurst: begin
        if (xfer) begin
          idle_cnt_d = '0;
          if (win_last) begin
            state_d  = StIdle;
            rr_ptr_d = next_idx(owner_q);
          end
        end else if (idle_cnt_q == CntLast) begin
          state_d       = StIdle;
          rr_ptr_d      = next_idx(owner_q);
          idle_cnt_d    = '0;
          timeout_err_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      grant_q       <= '0;
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: inputs change on the falling edge, outputs
// are sampled 1 ns later.
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned BW   = 5;
  localparam int unsigned TO   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NREQ(NREQ), .BITWIDTH(BW)) bus ();

  fifo_write_arbiter #(
    .NREQ     (NREQ),
    .BITWIDTH (BW),
    .TIMEOUT  (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] dat [NREQ] = '{5'h03, 5'h11, 5'h09, 5'h1e};

  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                       input logic full, input logic ren);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.fifo_full = full;
    bus.fifo_rEn  = ren;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 1'b0, 1'b0);
    @(negedge clk); #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++;
      $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    total++; if (bus.fifo_wEn !== 1'b0) begin bad++;
      $display("FAIL reset_wen: got %b want 0", bus.fifo_wEn); end
    total++; if (bus.fifo_dIn !== 5'h00) begin bad++;
      $display("FAIL reset_din: got %h want 00", bus.fifo_dIn); end
    total++; if (bus.locked !== 1'b0) begin bad++;
      $display("FAIL reset_locked: got %b want 0", bus.locked); end
    total++; if (bus.grant_id !== 2'd0) begin bad++;
      $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++;
      $display("FAIL reset_terr: got %b want 0", bus.timeout_err); end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  // All valid, single-beat bursts: grants rotate 0,1,2,3,0; leaves rr_ptr at 1.
  task automatic test_round_robin();
    logic [NREQ-1:0] exp_rdy;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      exp_rdy = '0;
      exp_rdy[e] = 1'b1;
      @(negedge clk); drive(4'b1111, 4'b1111, 1'b0, 1'b0); #1;
      total++; if (bus.grant_id !== 2'(e)) begin bad++;
        $display("FAIL rr_grant[%0d]: got %0d want %0d", k, bus.grant_id, e); end
      total++; if (bus.req_ready !== exp_rdy) begin bad++;
        $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.req_ready, exp_rdy); end
      total++; if (bus.fifo_wEn !== 1'b1) begin bad++;
        $display("FAIL rr_wen[%0d]: got %b want 1", k, bus.fifo_wEn); end
      total++; if (bus.fifo_dIn !== dat[e]) begin bad++;
        $display("FAIL rr_din[%0d]: got %h want %h", k, bus.fifo_dIn, dat[e]); end
    end
    @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  // Requester 1 locks (rr_ptr=1) while requester 2 waits; leaves rr_ptr at 3.
  task automatic test_burst_lock();
    @(negedge clk); drive(4'b0110, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.req_ready !== 4'b0010 || bus.grant_id !== 2'd1) begin bad++;
      $display("FAIL lock_first: ready %b grant %0d want 0010/1", bus.req_ready, bus.grant_id); end
    // Owner drops valid: lock is kept, nobody else gets ready.
    @(negedge clk); drive(4'b0100, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.locked !== 1'b1 || bus.req_ready !== 4'b0000 || bus.fifo_wEn !== 1'b0) begin
      bad++; $display("FAIL lock_gap: locked %b ready %b wen %b want 1/0000/0",
                      bus.locked, bus.req_ready, bus.fifo_wEn); end
    total++; if (bus.grant_id !== 2'd1) begin bad++;
      $display("FAIL lock_gap_grant: got %0d want 1", bus.grant_id); end
    @(negedge clk); drive(4'b0110, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.req_ready !== 4'b0010 || bus.fifo_dIn !== dat[1]) begin bad++;
      $display("FAIL lock_mid: ready %b din %h want 0010/%h", bus.req_ready, bus.fifo_dIn, dat[1]); end
    @(negedge clk); drive(4'b0110, 4'b0010, 1'b0, 1'b0); #1;
    total++; if (bus.req_ready !== 4'b0010 || bus.fifo_wEn !== 1'b1) begin bad++;
      $display("FAIL lock_last: ready %b wen %b want 0010/1", bus.req_ready, bus.fifo_wEn); end
    @(negedge clk); drive(4'b0110, 4'b0110, 1'b0, 1'b0); #1;
    total++; if (bus.locked !== 1'b0 || bus.req_ready !== 4'b0100 || bus.grant_id !== 2'd2) begin
      bad++; $display("FAIL lock_next: locked %b ready %b grant %0d want 0/0100/2",
                      bus.locked, bus.req_ready, bus.grant_id); end
    total++; if (bus.fifo_dIn !== dat[2]) begin bad++;
      $display("FAIL lock_next_din: got %h want %h", bus.fifo_dIn, dat[2]); end
    @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.grant_id !== 2'd2 || bus.fifo_wEn !== 1'b0 || bus.fifo_dIn !== 5'h00) begin
      bad++; $display("FAIL grant_hold: grant %0d wen %b din %h want 2/0/00",
                      bus.grant_id, bus.fifo_wEn, bus.fifo_dIn); end
  endtask

  // rr_ptr=3: full FIFO blocks, full+read passes; leaves rr_ptr at 1.
  task automatic test_fifo_space();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); drive(4'b1000, 4'b1000, 1'b1, 1'b0); #1;
      total++; if (bus.req_ready !== 4'b0000 || bus.fifo_wEn !== 1'b0) begin bad++;
        $display("FAIL full_block[%0d]: ready %b wen %b want 0000/0", k, bus.req_ready, bus.fifo_wEn); end
      total++; if (bus.grant_id !== 2'd3 || bus.locked !== 1'b0) begin bad++;
        $display("FAIL full_hold[%0d]: grant %0d locked %b want 3/0", k, bus.grant_id, bus.locked); end
    end
    @(negedge clk); drive(4'b1000, 4'b1000, 1'b1, 1'b1); #1;
    total++; if (bus.req_ready !== 4'b1000 || bus.fifo_wEn !== 1'b1 || bus.fifo_dIn !== dat[3]) begin
      bad++; $display("FAIL full_read: ready %b wen %b din %h want 1000/1/%h",
                      bus.req_ready, bus.fifo_wEn, bus.fifo_dIn, dat[3]); end
    // rr_ptr advanced to 0, so 0 beats 3.
    @(negedge clk); drive(4'b1001, 4'b1001, 1'b0, 1'b0); #1;
    total++; if (bus.grant_id !== 2'd0) begin bad++;
      $display("FAIL full_ptr: got %0d want 0", bus.grant_id); end
    @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  // rr_ptr=1: requester 0 locks then idles 15 cycles; leaves rr_ptr at 2.
  task automatic test_timeout();
    @(negedge clk); drive(4'b0001, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.req_ready !== 4'b0001 || bus.grant_id !== 2'd0) begin bad++;
      $display("FAIL to_lock: ready %b grant %0d want 0001/0", bus.req_ready, bus.grant_id); end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0); #1;
      total++; if (bus.locked !== 1'b1 || bus.timeout_err !== 1'b0) begin bad++;
        $display("FAIL to_wait[%0d]: locked %b terr %b want 1/0", k, bus.locked, bus.timeout_err); end
    end
    @(negedge clk); #1;
    total++; if (bus.locked !== 1'b0 || bus.timeout_err !== 1'b1) begin bad++;
      $display("FAIL to_fire: locked %b terr %b want 0/1", bus.locked, bus.timeout_err); end
    @(negedge clk); drive(4'b0011, 4'b0011, 1'b0, 1'b0); #1;
    total++; if (bus.timeout_err !== 1'b0) begin bad++;
      $display("FAIL to_pulse: got %b want 0", bus.timeout_err); end
    total++; if (bus.grant_id !== 2'd1) begin bad++;
      $display("FAIL to_ptr: got %0d want 1", bus.grant_id); end
    @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  // rr_ptr=2: a beat on the cycle the count would expire keeps the lock; leaves rr_ptr at 3.
  task automatic test_timeout_race();
    @(negedge clk); drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    @(negedge clk); drive(4'b0100, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.fifo_wEn !== 1'b1 || bus.locked !== 1'b1) begin bad++;
      $display("FAIL race_beat: wen %b locked %b want 1/1", bus.fifo_wEn, bus.locked); end
    @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.locked !== 1'b1 || bus.timeout_err !== 1'b0) begin bad++;
      $display("FAIL race_keep: locked %b terr %b want 1/0", bus.locked, bus.timeout_err); end
    @(negedge clk); drive(4'b0100, 4'b0100, 1'b0, 1'b0);
    @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.locked !== 1'b0 || bus.timeout_err !== 1'b0) begin bad++;
      $display("FAIL race_release: locked %b terr %b want 0/0", bus.locked, bus.timeout_err); end
  endtask

  // rr_ptr=3: requester 3 locks, then reset abandons the burst.
  task automatic test_reset_mid_burst();
    @(negedge clk); drive(4'b1000, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.grant_id !== 2'd3) begin bad++;
      $display("FAIL rstb_lock: got %0d want 3", bus.grant_id); end
    @(negedge clk); rst = 1'b1; drive(4'b1000, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.req_ready !== 4'b0000 || bus.fifo_wEn !== 1'b0) begin bad++;
      $display("FAIL rstb_gate: ready %b wen %b want 0000/0", bus.req_ready, bus.fifo_wEn); end
    @(negedge clk); rst = 1'b0; drive(4'b0000, 4'b0000, 1'b0, 1'b0); #1;
    total++; if (bus.locked !== 1'b0 || bus.grant_id !== 2'd0 || bus.timeout_err !== 1'b0) begin
      bad++; $display("FAIL rstb_after: locked %b grant %0d terr %b want 0/0/0",
                      bus.locked, bus.grant_id, bus.timeout_err); end
    @(negedge clk); drive(4'b1001, 4'b1001, 1'b0, 1'b0); #1;
    total++; if (bus.grant_id !== 2'd0 || bus.timeout_err !== 1'b0) begin bad++;
      $display("FAIL rstb_ptr: grant %0d terr %b want 0/0", bus.grant_id, bus.timeout_err); end
    @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    bus.req_data = {dat[3], dat[2], dat[1], dat[0]};
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_fifo_space();
    test_timeout();
    test_timeout_race();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter BITWIDTH, default 5, SHALL set the data width; it matches the shared FIFO data width.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum idle cycles allowed inside a locked burst.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester beat valid.
REQ-007 req_data  input  NREQ*BITWIDTH  per-requester beat data; requester i occupies bits [i*BITWIDTH +: BITWIDTH].
REQ-008 req_last  input  NREQ  marks the final beat of a burst.
REQ-009 req_ready  output  NREQ  per-requester beat accept; at most one bit set.
REQ-010 fifo_full  input  1  full flag from the shared FIFO.
REQ-011 fifo_rEn  input  1  read enable currently applied to the shared FIFO.
REQ-012 fifo_wEn  output  1  write enable to the shared FIFO.
REQ-013 fifo_dIn  output  BITWIDTH  write data to the shared FIFO.
REQ-014 grant_id  output  clog2(NREQ)  index of the currently selected requester.
REQ-015 locked  output  1  high while in BURST state.
REQ-016 timeout_err  output  1  one-cycle pulse on burst abort.

Function
REQ-017 States SHALL be IDLE and BURST, plus registers rr_ptr, owner and idle_cnt.
REQ-018 Space SHALL be defined as (!fifo_full | fifo_rEn), because the FIFO accepts a write when full with a simultaneous read.
REQ-019 In IDLE, the winner SHALL be the first requester with valid set, scanning from rr_ptr upward with modulo-NREQ wrap; the winner is combinational and not sticky.
REQ-020 In BURST, only requester owner SHALL be eligible; all other req_ready bits SHALL be 0.
REQ-021 req_ready[winner] SHALL equal space; a beat transfers when req_valid & req_ready (zero latency).
REQ-022 fifo_wEn SHALL be high exactly on a transfer; fifo_dIn SHALL be the winner's data, and 0 when there is no winner.
REQ-023 Transfer with last=1 in either state: next state IDLE, and rr_ptr <= winner+1 mod NREQ.
REQ-024 Transfer with last=0 in IDLE: next state BURST, and owner <= winner.
REQ-025 Transfer with last=0 in BURST: stay in BURST.
REQ-026 If there is no transfer in IDLE (no valid, or no space), state and rr_ptr SHALL be unchanged.
REQ-027 In BURST, idle_cnt SHALL clear on each transfer and increment otherwise.
REQ-028 When idle_cnt reaches TIMEOUT without a transfer: timeout_err pulses, next state IDLE, and rr_ptr <= owner+1.
REQ-029 A transfer in the same cycle the count would hit TIMEOUT SHALL win; no error is raised.
REQ-030 grant_id SHALL show the winner, or owner in BURST; it holds its last value when there is no winner.
REQ-031 A requester lowering valid mid-burst SHALL keep the lock; only last or timeout releases it.

Reset
REQ-032 On rst: state IDLE, rr_ptr 0, owner 0, idle_cnt 0, grant_id 0, locked 0, timeout_err 0.
REQ-033 During rst, req_ready, fifo_wEn and fifo_dIn SHALL be 0, regardless of inputs.
REQ-034 rst mid-burst SHALL abandon the burst without asserting timeout_err.

Structure
REQ-035 A shared package SHALL hold the state enumeration and the default values of BITWIDTH and TIMEOUT; BITWIDTH is shared with the FIFO.
REQ-036 The rotating priority scan SHALL be one sub-module, rr_pick (inputs: request vector and start pointer; outputs: index and found).

Verification
REQ-037 All NREQ valid with last=1, space always available -> grants 0,1,2,3,0, one beat per cycle, fifo_dIn matching each requester's data.
REQ-038 Requester 1 sends a 3-beat burst while requester 2 is valid -> requester 2 gets no ready until requester 1's last beat; then requester 2 is granted next cycle.
REQ-039 fifo_full=1, fifo_rEn=0 -> no fifo_wEn, state held; fifo_full=1, fifo_rEn=1 -> the beat is written.
REQ-040 Requester 0 locks and then drops valid for 15 cycles -> timeout_err pulses once, locked falls, rr_ptr=1.
REQ-041 rst asserted during a burst -> the next cycle has locked=0, grant_id=0, and no timeout_err.
